// File: rtl/imm_gen_pipe_pkg.sv
// Shared types for the pipelined immediate generator: format select,
// skid-buffer state and a width-generic entry record.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I     = 3'b000,
    IMM_S     = 3'b001,
    IMM_B     = 3'b010,
    IMM_J     = 3'b011,
    IMM_U     = 3'b100,
    IMM_SHAMT = 3'b101
  } imm_src_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } buf_state_e;

  localparam int unsigned IMM_MAX_W = 32'd64;
  localparam int unsigned TAG_MAX_W = 32'd16;

  // Entry sized for the widest configuration; narrower builds use the low bits.
  typedef struct packed {
    logic [IMM_MAX_W-1:0] imm;
    logic [TAG_MAX_W-1:0] tag;
    logic                 err;
  } imm_entry_t;

  function automatic logic imm_src_legal(input logic [2:0] src);
    logic legal_s;
    case (src)
      3'b110:  legal_s = 1'b0;
      3'b111:  legal_s = 1'b0;
      default: legal_s = 1'b1;
    endcase
    return legal_s;
  endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Input/output handshake bundle of the immediate generator; the block is
// the slave, the decode stage / consumer side is the master.
interface imm_gen_pipe_if #(
  parameter int unsigned XLEN  = 32'd32,
  parameter int unsigned TAG_W = 32'd5
);
  logic             in_valid;
  logic             in_ready;
  logic [31:7]      in_instr;
  logic [2:0]       in_imm_src;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  modport master (
    output in_valid, in_instr, in_imm_src, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, out_err
  );

  modport slave (
    input  in_valid, in_instr, in_imm_src, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag, out_err
  );
endinterface

// File: rtl/imm_gen_pipe_ext.sv
// Purely combinational immediate extender: builds each RISC-V immediate as a
// narrow field and widens it to XLEN by sign or zero extension.
module imm_ext_comb
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32'd32
) (
  input  logic [31:7]     instr,
  input  logic [2:0]      imm_src,
  output logic [XLEN-1:0] imm,
  output logic            err
);

  logic [11:0] i_imm_s;
  logic [11:0] s_imm_s;
  logic [12:0] b_imm_s;
  logic [20:0] j_imm_s;
  logic [31:0] u_imm_s;
  logic [5:0]  sh_imm_s;

  assign i_imm_s  = instr[31:20];
  assign s_imm_s  = {instr[31:25], instr[11:7]};
  assign b_imm_s  = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign j_imm_s  = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign u_imm_s  = {instr[31:12], 12'h000};
  // Bit 25 only belongs to the shift amount on RV64.
  assign sh_imm_s = {instr[25] & (XLEN == 32'd64), instr[24:20]};

  // Format select: signed casts widen with sign, unsigned shamt with zeros.
  always_comb begin
    imm = {XLEN{1'b0}};
    err = ~imm_src_legal(imm_src);
    case (imm_src_e'(imm_src))
      IMM_I:     imm = XLEN'($signed(i_imm_s));
      IMM_S:     imm = XLEN'($signed(s_imm_s));
      IMM_B:     imm = XLEN'($signed(b_imm_s));
      IMM_J:     imm = XLEN'($signed(j_imm_s));
      IMM_U:     imm = XLEN'($signed(u_imm_s));
      IMM_SHAMT: imm = XLEN'(sh_imm_s);
      default:   imm = {XLEN{1'b0}};
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: extends on input, registers the result in a
// 2-entry skid buffer so in_ready never depends combinationally on out_ready.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = 32'd32,
  parameter int unsigned TAG_W = 32'd5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  imm_gen_pipe_if.slave  bus
);

  localparam int unsigned ENTRY_W = XLEN + TAG_W + 32'd1;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             err;
  } entry_t;

  buf_state_e      state_r;
  entry_t          main_r;
  entry_t          skid_r;
  entry_t          new_s;
  logic            out_valid_r;
  logic            in_ready_r;
  logic            push_s;
  logic            pop_s;
  logic [XLEN-1:0] ext_imm_s;
  logic            ext_err_s;

  imm_ext_comb #(.XLEN(XLEN)) u_ext (
    .instr   (bus.in_instr),
    .imm_src (bus.in_imm_src),
    .imm     (ext_imm_s),
    .err     (ext_err_s)
  );

  assign new_s  = {ext_imm_s, bus.in_tag, ext_err_s};
  assign push_s = bus.in_valid & in_ready_r;
  assign pop_s  = out_valid_r & bus.out_ready;

  // Skid FSM: handshake flags are registered alongside the state they decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_EMPTY;
      main_r      <= {ENTRY_W{1'b0}};
      skid_r      <= {ENTRY_W{1'b0}};
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else if (flush) begin
      state_r     <= ST_EMPTY;
      main_r      <= {ENTRY_W{1'b0}};
      skid_r      <= {ENTRY_W{1'b0}};
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (push_s) begin
            main_r      <= new_s;
            state_r     <= ST_ONE;
            out_valid_r <= 1'b1;
            in_ready_r  <= 1'b1;
          end
        end
        ST_ONE: begin
          if (push_s && pop_s) begin
            main_r <= new_s;
          end else if (push_s) begin
            skid_r     <= new_s;
            state_r    <= ST_TWO;
            in_ready_r <= 1'b0;
          end else if (pop_s) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only a pop can move the buffer.
          if (pop_s) begin
            main_r     <= skid_r;
            state_r    <= ST_ONE;
            in_ready_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_EMPTY;
          main_r      <= {ENTRY_W{1'b0}};
          skid_r      <= {ENTRY_W{1'b0}};
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_imm   = main_r.imm;
  assign bus.out_tag   = main_r.tag;
  assign bus.out_err   = main_r.err;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: an XLEN=32 and an XLEN=64 instance are
// driven with directed vectors; monitors pop expected entries on each output.
module tb_imm_gen_pipe;
  import imm_pkg::*;

  localparam int unsigned TW = 32'd5;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  int checks   = 0;
  int failures = 0;

  imm_entry_t q32[$];
  imm_entry_t q64[$];

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(TW)) b32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(TW)) b64 ();

  imm_gen_pipe #(.XLEN(32), .TAG_W(TW)) dut32 (
    .clk(clk), .reset(reset), .flush(flush), .bus(b32.slave)
  );
  imm_gen_pipe #(.XLEN(64), .TAG_W(TW)) dut64 (
    .clk(clk), .reset(reset), .flush(flush), .bus(b64.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Present one entry, wait (bounded) for in_ready, log the expectation at the accepting edge.
  task automatic drive(input bit is64, input logic [31:0] w, input logic [2:0] src,
                       input logic [TW-1:0] tag, input logic [63:0] eimm, input logic eerr);
    imm_entry_t e;
    int n;
    e.imm = eimm;
    e.tag = 16'(tag);
    e.err = eerr;
    if (is64) begin
      b64.in_valid = 1'b1; b64.in_instr = w[31:7]; b64.in_imm_src = src; b64.in_tag = tag;
    end else begin
      b32.in_valid = 1'b1; b32.in_instr = w[31:7]; b32.in_imm_src = src; b32.in_tag = tag;
    end
    n = 0;
    @(negedge clk);
    while (((is64 ? b64.in_ready : b32.in_ready) !== 1'b1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL push_timeout actual in_ready=0 required in_ready=1 tag=%0d", tag);
    end else if (is64) begin
      q64.push_back(e);
    end else begin
      q32.push_back(e);
    end
    @(posedge clk);
    #1;
    if (is64) b64.in_valid = 1'b0;
    else      b32.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q32.size() != 0 || q64.size() != 0) && n < 40) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_pending", 64'(q32.size() + q64.size()), 64'd0);
  endtask

  // Monitor for the 64-bit instance.
  always @(negedge clk) begin : mon64
    imm_entry_t e;
    if (reset === 1'b0 && b64.out_valid === 1'b1 && b64.out_ready === 1'b1) begin
      checks++;
      if (q64.size() == 0) begin
        failures++;
        $display("FAIL out64_unexpected actual tag=%0d imm=0x%0h required no output", b64.out_tag, b64.out_imm);
      end else begin
        e = q64.pop_front();
        if (b64.out_imm !== e.imm || b64.out_tag !== e.tag[TW-1:0] || b64.out_err !== e.err) begin
          failures++;
          $display("FAIL out64 actual imm=0x%0h tag=%0d err=%0b required imm=0x%0h tag=%0d err=%0b",
                   b64.out_imm, b64.out_tag, b64.out_err, e.imm, e.tag[TW-1:0], e.err);
        end
      end
    end
  end

  // Monitor for the 32-bit instance.
  always @(negedge clk) begin : mon32
    imm_entry_t e;
    if (reset === 1'b0 && b32.out_valid === 1'b1 && b32.out_ready === 1'b1) begin
      checks++;
      if (q32.size() == 0) begin
        failures++;
        $display("FAIL out32_unexpected actual tag=%0d imm=0x%0h required no output", b32.out_tag, b32.out_imm);
      end else begin
        e = q32.pop_front();
        if (b32.out_imm !== e.imm[31:0] || b32.out_tag !== e.tag[TW-1:0] || b32.out_err !== e.err) begin
          failures++;
          $display("FAIL out32 actual imm=0x%0h tag=%0d err=%0b required imm=0x%0h tag=%0d err=%0b",
                   b32.out_imm, b32.out_tag, b32.out_err, e.imm[31:0], e.tag[TW-1:0], e.err);
        end
      end
    end
  end

  initial begin
    logic [31:0] w;
    imm_entry_t e;
    reset = 1'b1;
    flush = 1'b0;
    b32.in_valid = 1'b0; b32.in_instr = '0; b32.in_imm_src = 3'b000; b32.in_tag = '0; b32.out_ready = 1'b1;
    b64.in_valid = 1'b0; b64.in_instr = '0; b64.in_imm_src = 3'b000; b64.in_tag = '0; b64.out_ready = 1'b1;
    #1;
    chk("rst_in_ready32", 64'(b32.in_ready), 64'd1);
    chk("rst_out_valid32", 64'(b32.out_valid), 64'd0);
    chk("rst_out_imm32", 64'(b32.out_imm), 64'd0);
    chk("rst_in_ready64", 64'(b64.in_ready), 64'd1);
    chk("rst_out_valid64", 64'(b64.out_valid), 64'd0);
    chk("rst_out_imm64", b64.out_imm, 64'd0);
    chk("rst_out_tag64", 64'(b64.out_tag), 64'd0);
    chk("rst_out_err64", 64'(b64.out_err), 64'd0);
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b0;

    // XLEN=32 directed formats
    drive(1'b0, 32'hFFF00093, 3'b000, 5'd1, 64'h00000000FFFFFFFF, 1'b0);
    chk("latency32_out_valid", 64'(b32.out_valid), 64'd1);
    drive(1'b0, 32'hFE112E23, 3'b001, 5'd2, 64'h00000000FFFFFFFC, 1'b0);
    drive(1'b0, 32'h03F09093, 3'b101, 5'd3, 64'h000000000000001F, 1'b0);
    drive(1'b0, 32'h80000063, 3'b010, 5'd4, 64'h00000000FFFFF000, 1'b0);
    drive(1'b0, 32'h800002B7, 3'b100, 5'd5, 64'h0000000080000000, 1'b0);
    drive(1'b0, 32'hFFF00093, 3'b110, 5'd6, 64'h0000000000000000, 1'b1);
    drive(1'b0, 32'h00100093, 3'b000, 5'd7, 64'h0000000000000001, 1'b0);

    // XLEN=64 directed formats
    drive(1'b1, 32'h123452B7, 3'b100, 5'd1, 64'h0000000012345000, 1'b0);
    drive(1'b1, 32'h03F09093, 3'b101, 5'd2, 64'h000000000000003F, 1'b0);
    drive(1'b1, 32'hFFDFF06F, 3'b011, 5'd3, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    drive(1'b1, 32'h7FF00093, 3'b000, 5'd4, 64'h00000000000007FF, 1'b0);
    drive(1'b1, 32'h800002B7, 3'b100, 5'd5, 64'hFFFFFFFF80000000, 1'b0);
    drive(1'b1, 32'h00000463, 3'b010, 5'd6, 64'h0000000000000008, 1'b0);
    drive(1'b1, 32'h0080006F, 3'b011, 5'd7, 64'h0000000000000008, 1'b0);
    drive(1'b1, 32'h00112E23, 3'b001, 5'd8, 64'h000000000000001C, 1'b0);
    drive(1'b1, 32'hFFFFFFFF, 3'b111, 5'd9, 64'h0000000000000000, 1'b1);
    drive(1'b1, 32'h00100093, 3'b000, 5'd10, 64'h0000000000000001, 1'b0);
    drain();

    // Backpressure: two entries fill the buffer, then drain in order
    b64.out_ready = 1'b0;
    drive(1'b1, 32'h123452B7, 3'b100, 5'd1, 64'h0000000012345000, 1'b0);
    drive(1'b1, 32'hFFF00093, 3'b000, 5'd2, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    chk("bp_in_ready_low", 64'(b64.in_ready), 64'd0);
    @(posedge clk); #1;
    chk("bp_head_tag_stable", 64'(b64.out_tag), 64'd1);
    chk("bp_head_imm_stable", b64.out_imm, 64'h0000000012345000);
    b64.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_in_ready_back", 64'(b64.in_ready), 64'd1);
    drain();

    // Throughput: eight back-to-back pushes with out_ready high
    for (int i = 0; i < 8; i++) begin
      w = 32'h00000093 | (32'(i) << 20);
      b64.in_valid = 1'b1; b64.in_instr = w[31:7]; b64.in_imm_src = 3'b000; b64.in_tag = 5'(i + 16);
      @(negedge clk);
      chk("tput_in_ready", 64'(b64.in_ready), 64'd1);
      if (i > 0) chk("tput_out_valid", 64'(b64.out_valid), 64'd1);
      e.imm = 64'(i); e.tag = 16'(i + 16); e.err = 1'b0;
      q64.push_back(e);
      @(posedge clk); #1;
    end
    b64.in_valid = 1'b0;
    @(negedge clk);
    chk("tput_last_valid", 64'(b64.out_valid), 64'd1);
    drain();

    // Flush from TWO together with a presented entry
    b64.out_ready = 1'b0;
    drive(1'b1, 32'h7FF00093, 3'b000, 5'd9, 64'h00000000000007FF, 1'b0);
    drive(1'b1, 32'h123452B7, 3'b100, 5'd10, 64'h0000000012345000, 1'b0);
    chk("flush_pre_two", 64'(b64.in_ready), 64'd0);
    b64.in_valid = 1'b1; b64.in_instr = 25'h0000001; b64.in_imm_src = 3'b000; b64.in_tag = 5'd11;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    b64.in_valid = 1'b0;
    q64.delete();
    chk("flush_out_valid", 64'(b64.out_valid), 64'd0);
    chk("flush_in_ready", 64'(b64.in_ready), 64'd1);
    b64.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("flush_stays_empty", 64'(b64.out_valid), 64'd0);

    // Asynchronous reset mid-stream
    b64.out_ready = 1'b0;
    drive(1'b1, 32'h123452B7, 3'b100, 5'd12, 64'h0000000012345000, 1'b0);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", 64'(b64.out_valid), 64'd0);
    chk("arst_out_imm", b64.out_imm, 64'd0);
    chk("arst_out_tag", 64'(b64.out_tag), 64'd0);
    chk("arst_out_err", 64'(b64.out_err), 64'd0);
    chk("arst_in_ready", 64'(b64.in_ready), 64'd1);
    q64.delete();
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b0;
    b64.out_ready = 1'b1;
    drive(1'b1, 32'hFE112E23, 3'b001, 5'd13, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    chk("first_push_after_reset", 64'(b64.out_valid), 64'd1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
